// File: rtl/teclado_display_ctrl.sv
// Front-panel controller: 4x4 keypad scanner, 3-digit 7-segment multiplexer and R/G/B motor sequencer.
// Optional macro KEYPAD_HEX_KEYS_EN reports the A-D, * and # keys (codes 10-15) as well as 0-9.
module teclado_display_ctrl #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [4:0] digito,
    output logic       cambio_digito,
    input  logic [4:0] c,
    input  logic [4:0] d,
    input  logic [4:0] u,
    output logic [6:0] segmentos,
    output logic [2:0] enable,
    input  logic       enter,
    input  logic       RGB_full,
    input  logic [2:0] flags,
    output logic [2:0] Motores
);

    // state    | meaning
    // ---------+---------------------------------------------
    // ST_IDLE  | waiting for memory to hold a full R/G/B set
    // ST_READY | set complete, waiting for an enter edge
    // ST_RUN_R | red motor on until flags[0]
    // ST_RUN_G | green motor on until flags[1]
    // ST_RUN_B | blue motor on until flags[2]
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RUN_R,
        ST_RUN_G,
        ST_RUN_B
    } fsm_state_e;

    typedef enum logic {
        KP_SCAN,
        KP_HELD
    } kp_state_e;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    function automatic logic [6:0] seg_pat(input logic [4:0] v);
        case (v)
            5'd0:    seg_pat = 7'b1000000;
            5'd1:    seg_pat = 7'b1111001;
            5'd2:    seg_pat = 7'b0100100;
            5'd3:    seg_pat = 7'b0110000;
            5'd4:    seg_pat = 7'b0011001;
            5'd5:    seg_pat = 7'b0010010;
            5'd6:    seg_pat = 7'b0000010;
            5'd7:    seg_pat = 7'b1111000;
            5'd8:    seg_pat = 7'b0000000;
            5'd9:    seg_pat = 7'b0010000;
            default: seg_pat = 7'b0111111;
        endcase
    endfunction

    // ---------------- tick generator ----------------
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) tick_cnt_q <= '0;
        else       tick_cnt_q <= tick_cnt_d;
    end

    // ---------------- keypad ----------------
    kp_state_e  kp_state_q, kp_state_d;
    logic [3:0] col_q, col_d;
    logic [4:0] digito_q, digito_d;
    logic       cambio_q, cambio_d;
    logic [1:0] row_idx, col_idx;
    logic [4:0] key_code;
    logic       key_report;
    logic       no_key;

    always_comb begin
        no_key = (fila == 4'hF);
        // lowest-index active row wins when several keys share a column
        if      (!fila[0]) row_idx = 2'd0;
        else if (!fila[1]) row_idx = 2'd1;
        else if (!fila[2]) row_idx = 2'd2;
        else               row_idx = 2'd3;
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
        case ({row_idx, col_idx})
            4'h0: key_code = 5'd1;
            4'h1: key_code = 5'd2;
            4'h2: key_code = 5'd3;
            4'h3: key_code = 5'd10;
            4'h4: key_code = 5'd4;
            4'h5: key_code = 5'd5;
            4'h6: key_code = 5'd6;
            4'h7: key_code = 5'd11;
            4'h8: key_code = 5'd7;
            4'h9: key_code = 5'd8;
            4'hA: key_code = 5'd9;
            4'hB: key_code = 5'd12;
            4'hC: key_code = 5'd14;
            4'hD: key_code = 5'd0;
            4'hE: key_code = 5'd15;
            default: key_code = 5'd13;
        endcase
    end

`ifdef KEYPAD_HEX_KEYS_EN
    assign key_report = 1'b1;
`else
    assign key_report = (key_code < 5'd10);
`endif

    always_comb begin
        kp_state_d = kp_state_q;
        col_d      = col_q;
        digito_d   = digito_q;
        cambio_d   = 1'b0;
        case (kp_state_q)
            KP_SCAN: begin
                if (tick) begin
                    if (no_key) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        kp_state_d = KP_HELD;
                        if (key_report) begin
                            digito_d = key_code;
                            cambio_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (tick && no_key) kp_state_d = KP_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kp_state_q <= KP_SCAN;
            col_q      <= 4'b1110;
            digito_q   <= 5'd31;
            cambio_q   <= 1'b0;
        end else begin
            kp_state_q <= kp_state_d;
            col_q      <= col_d;
            digito_q   <= digito_d;
            cambio_q   <= cambio_d;
        end
    end

    assign col           = col_q;
    assign digito        = digito_q;
    assign cambio_digito = cambio_q;

    // ---------------- display multiplexer ----------------
    logic [1:0] dig_idx_q, dig_idx_d;
    logic [2:0] enable_q, enable_d;
    logic [6:0] seg_q, seg_d;
    logic [4:0] disp_val;

    always_comb begin
        dig_idx_d = dig_idx_q;
        enable_d  = enable_q;
        seg_d     = seg_q;
        case (dig_idx_q)
            2'd0:    disp_val = u;
            2'd1:    disp_val = d;
            default: disp_val = c;
        endcase
        if (tick) begin
            case (dig_idx_q)
                2'd0:    enable_d = 3'b110;
                2'd1:    enable_d = 3'b101;
                default: enable_d = 3'b011;
            endcase
            seg_d     = seg_pat(disp_val);
            dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_idx_q <= 2'd0;
            enable_q  <= 3'b110;
            seg_q     <= 7'b1111111;
        end else begin
            dig_idx_q <= dig_idx_d;
            enable_q  <= enable_d;
            seg_q     <= seg_d;
        end
    end

    assign enable    = enable_q;
    assign segmentos = seg_q;

    // ---------------- enter synchronizer ----------------
    logic ent_s1_q, ent_s1_d;
    logic ent_s2_q, ent_s2_d;
    logic ent_prev_q, ent_prev_d;
    logic enter_rise;

    always_comb begin
        ent_s1_d   = enter;
        ent_s2_d   = ent_s1_q;
        ent_prev_d = ent_s2_q;
        enter_rise = ent_s2_q & ~ent_prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_s1_q   <= 1'b0;
            ent_s2_q   <= 1'b0;
            ent_prev_q <= 1'b0;
        end else begin
            ent_s1_q   <= ent_s1_d;
            ent_s2_q   <= ent_s2_d;
            ent_prev_q <= ent_prev_d;
        end
    end

    // ---------------- motor sequencer ----------------
    fsm_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Motores = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (RGB_full) state_d = ST_READY;
            end
            ST_READY: begin
                if (!RGB_full)      state_d = ST_IDLE;
                else if (enter_rise) state_d = ST_RUN_R;
            end
            ST_RUN_R: begin
                Motores = 3'b001;
                if (flags[0]) state_d = ST_RUN_G;
            end
            ST_RUN_G: begin
                Motores = 3'b010;
                if (flags[1]) state_d = ST_RUN_B;
            end
            ST_RUN_B: begin
                Motores = 3'b100;
                if (flags[2]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_teclado_display_ctrl.sv
// Self-checking bench for teclado_display_ctrl (TICK_DIV=1): physical keypad model,
// display rotation model and an enter-history based sequencer model.
module tb_teclado_display_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fila;
    logic [3:0] col;
    logic [4:0] digito;
    logic       cambio_digito;
    logic [4:0] c, d, u;
    logic [6:0] segmentos;
    logic [2:0] enable;
    logic       enter;
    logic       RGB_full;
    logic [2:0] flags;
    logic [2:0] Motores;

    int n_checks = 0;
    int n_fail   = 0;

    // keypad model: pressed keys pull their row low only while their column is driven
    logic       key_down  = 1'b0;
    logic       key2_down = 1'b0;
    logic [1:0] key_r = 2'd0, key2_r = 2'd0, key_c = 2'd0;

    always_comb begin
        fila = 4'hF;
        if (col[key_c] == 1'b0) begin
            if (key_down)  fila[key_r]  = 1'b0;
            if (key2_down) fila[key2_r] = 1'b0;
        end
    end

    int code_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    teclado_display_ctrl #(.TICK_DIV(1)) dut (
        .clk(clk), .reset(reset), .fila(fila), .col(col), .digito(digito),
        .cambio_digito(cambio_digito), .c(c), .d(d), .u(u), .segmentos(segmentos),
        .enable(enable), .enter(enter), .RGB_full(RGB_full), .flags(flags), .Motores(Motores)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] col_of(input int k);
        logic [3:0] one = 4'b0001;
        return ~(one << k);
    endfunction

    function automatic logic [6:0] exp_seg(input int v);
        return (v > 9) ? 7'b0111111 : seg_tab[v];
    endfunction

    function automatic logic [2:0] motor_of(input int s);
        case (s)
            2:       return 3'b001;
            3:       return 3'b010;
            4:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // 0 idle, 1 ready, 2 run R, 3 run G, 4 run B
    function automatic int fsm_next(input int s, input logic full, input logic edg, input logic [2:0] fl);
        case (s)
            0:       return full ? 1 : 0;
            1:       return !full ? 0 : (edg ? 2 : 1);
            2:       return fl[0] ? 3 : 2;
            3:       return fl[1] ? 4 : 3;
            4:       return fl[2] ? 0 : 4;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        key_down = 1'b0; key2_down = 1'b0;
        do_reset();
        n_checks++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", col); end
        n_checks++; if (enable !== 3'b110) begin n_fail++; $display("FAIL reset_enable: got %b want 110", enable); end
        n_checks++; if (segmentos !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %b want 1111111", segmentos); end
        n_checks++; if (Motores !== 3'b000) begin n_fail++; $display("FAIL reset_motores: got %b want 000", Motores); end
        n_checks++; if (digito !== 5'd31) begin n_fail++; $display("FAIL reset_digito: got %0d want 31", digito); end
        n_checks++; if (cambio_digito !== 1'b0) begin n_fail++; $display("FAIL reset_cambio: got %b want 0", cambio_digito); end
    endtask

    task automatic test_keypad();
        int exp_dig;
        int r, cc, r2, pulses, code;
        bit two, rep;
        do_reset();
        exp_dig = 31;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (col !== col_of(k % 4)) begin
                n_fail++; $display("FAIL scan_rotate: got %b want %b", col, col_of(k % 4));
            end
        end
        for (int p = 0; p < 14; p++) begin
            if (p == 0) begin r = 1; cc = 2; two = 1'b0; end
            else begin
                r = $urandom_range(0, 3); cc = $urandom_range(0, 3);
                two = (r < 3) && ($urandom_range(0, 2) == 0);
            end
            r2 = two ? $urandom_range(r + 1, 3) : 0;
            key_r = 2'(r); key_c = 2'(cc); key2_r = 2'(r2);
            key_down = 1'b1; key2_down = two;
            pulses = 0;
            repeat (6) begin
                step();
                if (cambio_digito === 1'b1) pulses++;
            end
            code = code_tab[r][cc];
`ifdef KEYPAD_HEX_KEYS_EN
            rep = 1'b1;
`else
            rep = (code < 10);
`endif
            if (rep) exp_dig = code;
            n_checks++;
            if (pulses != (rep ? 1 : 0)) begin
                n_fail++; $display("FAIL key_pulses r%0d c%0d: got %0d want %0d", r, cc, pulses, rep ? 1 : 0);
            end
            n_checks++;
            if (digito !== 5'(exp_dig)) begin
                n_fail++; $display("FAIL key_digito r%0d c%0d: got %0d want %0d", r, cc, digito, exp_dig);
            end
            n_checks++;
            if (col !== col_of(cc)) begin
                n_fail++; $display("FAIL key_col_frozen: got %b want %b", col, col_of(cc));
            end
            key_down = 1'b0; key2_down = 1'b0;
            step();
            n_checks++;
            if (col !== col_of(cc)) begin
                n_fail++; $display("FAIL release_no_rotate: got %b want %b", col, col_of(cc));
            end
            step();
            n_checks++;
            if (col !== col_of((cc + 1) % 4)) begin
                n_fail++; $display("FAIL release_resume: got %b want %b", col, col_of((cc + 1) % 4));
            end
        end
    endtask

    task automatic test_display();
        int vals [3];
        int n;
        logic [2:0] one3;
        logic [2:0] exp_en;
        do_reset();
        n = 0;
        one3 = 3'b001;
        for (int i = 0; i < 12; i++) begin
            if (i < 3) begin vals[0] = 3; vals[1] = 2; vals[2] = 1; end
            else if (i < 6) begin
                vals[0] = 12; vals[1] = $urandom_range(0, 9); vals[2] = $urandom_range(0, 31);
            end else begin
                vals[0] = $urandom_range(0, 31); vals[1] = $urandom_range(0, 31); vals[2] = $urandom_range(0, 15);
            end
            u = 5'(vals[0]); d = 5'(vals[1]); c = 5'(vals[2]);
            step();
            exp_en = ~(one3 << (n % 3));
            n_checks++;
            if (enable !== exp_en) begin
                n_fail++; $display("FAIL disp_enable tick%0d: got %b want %b", n, enable, exp_en);
            end
            n_checks++;
            if (segmentos !== exp_seg(vals[n % 3])) begin
                n_fail++; $display("FAIL disp_seg tick%0d: got %b want %b", n, segmentos, exp_seg(vals[n % 3]));
            end
            n++;
        end
    endtask

    int   m_state;
    logic h1, h2, h3;

    task automatic fsm_step(input logic full, input logic en, input logic [2:0] fl, input logic rst);
        logic edg;
        RGB_full = full; enter = en; flags = fl; reset = rst;
        @(posedge clk);
        if (rst) begin
            m_state = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            edg = h2 & ~h3;
            m_state = fsm_next(m_state, full, edg, fl);
            h3 = h2; h2 = h1; h1 = en;
        end
        @(negedge clk);
        n_checks++;
        if (Motores !== motor_of(m_state)) begin
            n_fail++; $display("FAIL motores: got %b want %b (full=%b en=%b flags=%b rst=%b)",
                               Motores, motor_of(m_state), full, en, fl, rst);
        end
    endtask

    task automatic test_sequencer();
        do_reset();
        m_state = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        fsm_step(1'b1, 1'b0, 3'b000, 1'b0);
        repeat (3) fsm_step(1'b1, 1'b1, 3'b000, 1'b0);
        n_checks++;
        if (Motores !== 3'b001) begin n_fail++; $display("FAIL enter_latency: got %b want 001", Motores); end
        fsm_step(1'b1, 1'b1, 3'b001, 1'b0);
        fsm_step(1'b1, 1'b0, 3'b010, 1'b0);
        fsm_step(1'b1, 1'b0, 3'b100, 1'b0);
        n_checks++;
        if (Motores !== 3'b000) begin n_fail++; $display("FAIL run_b_done: got %b want 000", Motores); end
        fsm_step(1'b1, 1'b0, 3'b000, 1'b0);
        repeat (3) fsm_step(1'b1, 1'b1, 3'b000, 1'b0);
        fsm_step(1'b1, 1'b0, 3'b001, 1'b0);
        fsm_step(1'b1, 1'b0, 3'b101, 1'b0);
        n_checks++;
        if (Motores !== 3'b010) begin n_fail++; $display("FAIL foreign_flags: got %b want 010", Motores); end
        fsm_step(1'b1, 1'b0, 3'b101, 1'b1);
        n_checks++;
        if (Motores !== 3'b000) begin n_fail++; $display("FAIL reset_midrun: got %b want 000", Motores); end
        // enter edge while not READY must be discarded
        repeat (4) fsm_step(1'b0, 1'b1, 3'b000, 1'b0);
        repeat (4) fsm_step(1'b1, 1'b1, 3'b000, 1'b0);
        fsm_step(1'b1, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_sequencer_random();
        logic en_r, full_r, rst_r;
        logic [2:0] fl_r;
        en_r = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) en_r = ~en_r;
            full_r = ($urandom_range(0, 7) != 0);
            fl_r   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            rst_r  = ($urandom_range(0, 49) == 0);
            fsm_step(full_r, en_r, fl_r, rst_r);
        end
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; RGB_full = 1'b0; flags = 3'b000;
        c = 5'd0; d = 5'd0; u = 5'd0;
        test_reset();
        test_keypad();
        test_display();
        test_sequencer();
        test_sequencer_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
